fsm_serial_tx: RTL and testbench

FSM_SERIAL_TX -- requirements
Module: fsm_serial_tx

---
 rtl/fsm_serial_tx.sv | 159 +++++++++++++++
 tb/tb_fsm_serial_tx.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fsm_serial_tx.sv
// Byte-wide to serial transmitter: start bit, 8 data bits LSB first, optional even parity, 1 or 2 stop bits.
// Define FSM_SERIAL_TX_PARITY_EN to insert the even-parity bit between the data bits and the stop bits.
module fsm_serial_tx #(
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       dout,
    output logic       busy,
    output logic       frame_done
);

`ifdef FSM_SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    localparam logic [15:0] CNT_RELOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic        STOP_LAST  = 1'(STOP_BITS - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bitIdx_q, bitIdx_d;
    logic        stopIdx_q, stopIdx_d;
    logic [7:0]  shift_q, shift_d;
    logic        dout_q, dout_d;

    logic bitEnd;
    logic lastStop;
    logic accept;

    assign bitEnd     = (cnt_q == 16'd0);
    assign lastStop   = (state_q == STOP) && bitEnd && (stopIdx_q == STOP_LAST);
    assign din_ready  = (state_q == IDLE) || lastStop;
    assign accept     = din_valid && din_ready;
    assign busy       = (state_q != IDLE);
    assign frame_done = lastStop;
    assign dout       = dout_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            bitIdx_q  <= 3'd0;
            stopIdx_q <= 1'b0;
            shift_q   <= 8'd0;
            dout_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bitIdx_q  <= bitIdx_d;
            stopIdx_q <= stopIdx_d;
            shift_q   <= shift_d;
            dout_q    <= dout_d;
        end
    end

    // dout is registered, so each branch computes the line level for the bit that starts next cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bitIdx_d  = bitIdx_q;
        stopIdx_d = stopIdx_q;
        shift_d   = shift_q;
        dout_d    = dout_q;

        case (state_q)
            IDLE: begin
                dout_d = 1'b1;
            end
            START: begin
                if (bitEnd) begin
                    state_d  = DATA;
                    cnt_d    = CNT_RELOAD;
                    bitIdx_d = 3'd0;
                    dout_d   = shift_q[0];
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (bitEnd) begin
                    cnt_d = CNT_RELOAD;
                    if (bitIdx_q == 3'd7) begin
`ifdef FSM_SERIAL_TX_PARITY_EN
                        state_d = PARITY;
                        dout_d  = ^shift_q;
`else
                        state_d   = STOP;
                        stopIdx_d = 1'b0;
                        dout_d    = 1'b1;
`endif
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                        dout_d   = shift_q[bitIdx_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`ifdef FSM_SERIAL_TX_PARITY_EN
            PARITY: begin
                if (bitEnd) begin
                    state_d   = STOP;
                    cnt_d     = CNT_RELOAD;
                    stopIdx_d = 1'b0;
                    dout_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`endif
            STOP: begin
                dout_d = 1'b1;
                if (bitEnd) begin
                    cnt_d = CNT_RELOAD;
                    if (stopIdx_q == STOP_LAST) begin
                        state_d = IDLE;
                    end else begin
                        stopIdx_d = stopIdx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                dout_d  = 1'b1;
            end
        endcase

        // A handshake can only happen in IDLE or the last stop cycle; either way the next frame starts at once.
        if (accept) begin
            state_d   = START;
            cnt_d     = CNT_RELOAD;
            bitIdx_d  = 3'd0;
            stopIdx_d = 1'b0;
            shift_d   = din;
            dout_d    = 1'b0;
        end
    end

endmodule

// File: tb/tb_fsm_serial_tx.sv
// Directed bench for fsm_serial_tx: a CLKS_PER_BIT=1 instance driven from a table of frames,
// plus a CLKS_PER_BIT=4 instance for the stretched-bit case.
module tb_fsm_serial_tx;

    typedef struct {
        logic [7:0]  data;
        logic [10:0] seq;
        int          len;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       dinValid;
    logic       dinReady, dout, busy, frameDone;
    logic [7:0] din4;
    logic       dinValid4;
    logic       dinReady4, dout4, busy4, frameDone4;

    int total = 0;
    int bad   = 0;

    vec_t vecs[4];
    vec_t vec3C;

    fsm_serial_tx #(.CLKS_PER_BIT(1), .STOP_BITS(1)) dut1 (
        .clk(clk), .reset(reset), .din(din), .din_valid(dinValid),
        .din_ready(dinReady), .dout(dout), .busy(busy), .frame_done(frameDone)
    );

    fsm_serial_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut4 (
        .clk(clk), .reset(reset), .din(din4), .din_valid(dinValid4),
        .din_ready(dinReady4), .dout(dout4), .busy(busy4), .frame_done(frameDone4)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Handshake one byte on dut1; returns at the negedge of the first frame cycle.
    task automatic applyStimulus(input logic [7:0] data);
        @(negedge clk);
        din      = data;
        dinValid = 1'b1;
        @(negedge clk);
        dinValid = 1'b0;
        din      = ~data;
    endtask

    task automatic checkFrame(input string tag, input vec_t v);
        for (int c = 0; c < v.len; c++) begin
            checkOutput($sformatf("%s dout c%0d", tag, c), dout, v.seq[v.len-1-c]);
            checkOutput($sformatf("%s busy c%0d", tag, c), busy, 1'b1);
            checkOutput($sformatf("%s ready c%0d", tag, c), dinReady, c == v.len-1);
            checkOutput($sformatf("%s done c%0d", tag, c), frameDone, c == v.len-1);
            din      = 8'($urandom);
            dinValid = (c < v.len-2) ? 1'($urandom) : 1'b0;
            @(negedge clk);
        end
        checkOutput($sformatf("%s idle busy", tag), busy, 1'b0);
        checkOutput($sformatf("%s idle dout", tag), dout, 1'b1);
        checkOutput($sformatf("%s idle ready", tag), dinReady, 1'b1);
    endtask

    initial begin
`ifdef FSM_SERIAL_TX_PARITY_EN
        vecs[0] = '{8'hA5, 11'b01010010101, 11};
        vecs[1] = '{8'h00, 11'b00000000001, 11};
        vecs[2] = '{8'hFF, 11'b01111111101, 11};
        vecs[3] = '{8'h07, 11'b01110000011, 11};
        vec3C   = '{8'h3C, 11'b00011110001, 11};
`else
        vecs[0] = '{8'hA5, 11'b0101001011, 10};
        vecs[1] = '{8'h00, 11'b0000000001, 10};
        vecs[2] = '{8'hFF, 11'b0111111111, 10};
        vecs[3] = '{8'h07, 11'b0111000001, 10};
        vec3C   = '{8'h3C, 11'b0001111001, 10};
`endif
        reset     = 1'b0;
        din       = 8'h00;
        dinValid  = 1'b0;
        din4      = 8'h00;
        dinValid4 = 1'b0;

        // Two reset cycles, then release
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        checkOutput("reset dout", dout, 1'b1);
        checkOutput("reset ready", dinReady, 1'b1);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset done", frameDone, 1'b0);
        checkOutput("reset dout4", dout4, 1'b1);
        checkOutput("reset busy4", busy4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("idle busy %0d", i), busy, 1'b0);
            checkOutput($sformatf("idle dout %0d", i), dout, 1'b1);
        end

        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].data);
            checkFrame($sformatf("frame%0h", vecs[i].data), vecs[i]);
        end

        // Back-to-back 0x00 then 0xFF with din_valid held high
        @(negedge clk);
        din      = 8'h00;
        dinValid = 1'b1;
        @(negedge clk);
        din = 8'hFF;
        for (int c = 0; c < 2*vecs[1].len; c++) begin
            int L;
            L = vecs[1].len;
            if (c < L)
                checkOutput($sformatf("b2b dout c%0d", c), dout, vecs[1].seq[L-1-c]);
            else
                checkOutput($sformatf("b2b dout c%0d", c), dout, vecs[2].seq[L-1-(c-L)]);
            checkOutput($sformatf("b2b busy c%0d", c), busy, 1'b1);
            checkOutput($sformatf("b2b done c%0d", c), frameDone, (c == L-1) || (c == 2*L-1));
            if (c == L) dinValid = 1'b0;
            @(negedge clk);
        end
        checkOutput("b2b end busy", busy, 1'b0);
        checkOutput("b2b end dout", dout, 1'b1);

        // Stretched bits on the CLKS_PER_BIT=4 instance
        @(negedge clk);
        din4      = vec3C.data;
        dinValid4 = 1'b1;
        @(negedge clk);
        dinValid4 = 1'b0;
        din4      = 8'h5A;
        for (int c = 0; c < 4*vec3C.len; c++) begin
            checkOutput($sformatf("cpb4 dout c%0d", c), dout4, vec3C.seq[vec3C.len-1-c/4]);
            checkOutput($sformatf("cpb4 busy c%0d", c), busy4, 1'b1);
            checkOutput($sformatf("cpb4 ready c%0d", c), dinReady4, c == 4*vec3C.len-1);
            checkOutput($sformatf("cpb4 done c%0d", c), frameDone4, c == 4*vec3C.len-1);
            @(negedge clk);
        end
        checkOutput("cpb4 end busy", busy4, 1'b0);
        checkOutput("cpb4 end dout", dout4, 1'b1);

        // Reset during data bit 3 of 0xFF, with din_valid high through the reset cycles
        applyStimulus(8'hFF);
        repeat (4) @(negedge clk);
        checkOutput("abort pre dout", dout, 1'b1);
        checkOutput("abort pre busy", busy, 1'b1);
        reset    = 1'b0;
        dinValid = 1'b1;
        din      = 8'h00;
        @(negedge clk);
        checkOutput("abort dout", dout, 1'b1);
        checkOutput("abort busy", busy, 1'b0);
        checkOutput("abort ready", dinReady, 1'b1);
        checkOutput("abort done", frameDone, 1'b0);
        @(negedge clk);
        checkOutput("abort hold busy", busy, 1'b0);
        checkOutput("abort hold dout", dout, 1'b1);
        reset    = 1'b1;
        dinValid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checkOutput($sformatf("post dout %0d", i), dout, 1'b1);
            checkOutput($sformatf("post busy %0d", i), busy, 1'b0);
            checkOutput($sformatf("post done %0d", i), frameDone, 1'b0);
            checkOutput($sformatf("post ready %0d", i), dinReady, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
